app_mem_responder: RTL and testbench

APP_MEM_RESPONDER -- requirements
Module: app_mem_responder

---
 rtl/app_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_app_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/app_mem_responder.sv
// app_mem_responder: app-port memory responder with calibration delay,
// periodic refresh stalls, 2-deep write-data FIFO and fixed-latency reads.
// Ports: clk, reset (sync, active-high); app_addr/app_cmd/app_en/app_rdy
// command channel; app_wdf_data/mask/end/wren/rdy write-data channel;
// app_rd_data/valid/end read response; init_calib_complete status.
module app_mem_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int DEPTH_LOG2     = 8,
  parameter int READ_LATENCY   = 4,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_end,
  input  logic                        app_wdf_wren,
  output logic                        app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        init_calib_complete
);

  localparam int DW    = APP_DATA_WIDTH;
  localparam int MW    = APP_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RL    = READ_LATENCY;
  localparam int CCW   = ($clog2(CALIB_CYCLES + 1) > 5) ?
                         $clog2(CALIB_CYCLES + 1) : 5;
  localparam int RFW   = (REFRESH_PERIOD > 1) ?
                         $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CCW-1:0] CAL_LAST = CCW'(CALIB_CYCLES - 1);
  localparam logic [RFW-1:0] RF_LAST  = RFW'(REFRESH_PERIOD - 1);
  localparam bit             RF_EN    = (REFRESH_PERIOD > 0);

  typedef enum logic [1:0] {
    CALIB,
    IDLE,
    WR_WAIT_DATA,
    REFRESH
  } state_t;

  state_t state, state_nx;

  logic [CCW-1:0]        cal_cnt;
  logic                  cal_done;
  logic [RFW-1:0]        rf_cnt;
  logic                  rf_term;
  logic                  rf_pend;
  logic [1:0]            rf_len;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic [DW-1:0] f_data [2];
  logic [MW-1:0] f_mask [2];
  logic [1:0]    f_cnt;
  logic          w_slot;

  logic                  cmd_acc;
  logic                  wr_cmd;
  logic                  rd_cmd;
  logic                  wdf_acc;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  commit;
  logic                  we;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [DW-1:0]         c_data;
  logic [MW-1:0]         c_mask;

  logic [DW-1:0] mem [DEPTH];

  logic [RL-1:0] v_pipe;
  logic [DW-1:0] d_pipe [RL];

  logic unused_in;
  assign unused_in = ^{app_wdf_end, app_addr};

  // Word index ignores the byte/column offset and aliases upper bits.
  assign idx = app_addr[DEPTH_LOG2+2:3];

  assign app_rdy     = (state == IDLE);
  assign app_wdf_rdy = (state != CALIB) && (f_cnt < 2'd2);

  assign cmd_acc = app_en && app_rdy;
  assign wr_cmd  = cmd_acc && (app_cmd == 3'b000);
  assign rd_cmd  = cmd_acc && (app_cmd == 3'b001);
  assign wdf_acc = app_wdf_wren && app_wdf_rdy;

  // A beat consumed directly by a command never enters the FIFO.
  assign push = wdf_acc && !bypass;
  assign we   = commit && !reset;

  assign rf_term = RF_EN && (rf_cnt == RF_LAST);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    bypass   = 1'b0;
    commit   = 1'b0;
    c_idx    = idx;
    c_data   = f_data[0];
    c_mask   = f_mask[0];
    unique case (state)
      CALIB: begin
        if (cal_cnt == CAL_LAST) state_nx = IDLE;
      end
      IDLE: begin
        if (wr_cmd) begin
          if (f_cnt != 2'd0) begin
            commit = 1'b1;
            pop    = 1'b1;
          end else if (wdf_acc) begin
            commit = 1'b1;
            bypass = 1'b1;
            c_data = app_wdf_data;
            c_mask = app_wdf_mask;
          end else begin
            state_nx = WR_WAIT_DATA;
          end
        end
        // A write left waiting for data defers the refresh.
        if (rf_pend && state_nx == IDLE) state_nx = REFRESH;
      end
      WR_WAIT_DATA: begin
        c_idx = w_idx;
        if (wdf_acc) begin
          commit   = 1'b1;
          bypass   = 1'b1;
          c_data   = app_wdf_data;
          c_mask   = app_wdf_mask;
          state_nx = IDLE;
        end
      end
      REFRESH: begin
        if (rf_len == 2'd3) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CALIB;
      cal_cnt  <= '0;
      cal_done <= 1'b0;
      rf_cnt   <= '0;
      rf_pend  <= 1'b0;
      rf_len   <= 2'd0;
      f_cnt    <= 2'd0;
      w_idx    <= '0;
    end else begin
      state <= state_nx;
      if (state == CALIB) cal_cnt <= cal_cnt + CCW'(1);
      if (state == CALIB && state_nx == IDLE) cal_done <= 1'b1;
      f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
      if (state == IDLE && state_nx == WR_WAIT_DATA) w_idx <= idx;
      rf_len <= (state == REFRESH) ? rf_len + 2'd1 : 2'd0;
      if (RF_EN) rf_cnt <= rf_term ? '0 : rf_cnt + RFW'(1);
      if (state == IDLE && state_nx == REFRESH) rf_pend <= 1'b0;
      if (rf_term) rf_pend <= 1'b1;
    end
  end

  // FIFO head is always slot 0; a pop shifts slot 1 down.
  assign w_slot = (f_cnt == 2'd1) && !pop;

  always_ff @(posedge clk) begin
    if (pop) begin
      f_data[0] <= f_data[1];
      f_mask[0] <= f_mask[1];
    end
    if (push) begin
      f_data[w_slot] <= app_wdf_data;
      f_mask[w_slot] <= app_wdf_mask;
    end
  end

  // Backing store has no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MW; b++) begin
        if (!c_mask[b]) mem[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
      end
    end
  end

  // Data stages only advance behind a valid so the last
  // response stays on app_rd_data while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe <= '0;
      for (int i = 0; i < RL; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_cmd;
      if (rd_cmd) d_pipe[0] <= mem[idx];
      for (int i = 1; i < RL; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign app_rd_data         = d_pipe[RL-1];
  assign app_rd_data_valid   = v_pipe[RL-1];
  assign app_rd_data_end     = v_pipe[RL-1];
  assign init_calib_complete = cal_done;

endmodule

// File: tb/tb_app_mem_responder.sv
// tb_app_mem_responder: randomized + directed bench with a
// handshake-driven memory model and an in-order read scoreboard.
module tb_app_mem_responder;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int DL = 8;
  localparam int RL = 4;
  localparam int CC = 16;
  localparam int RP = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;

  app_mem_responder #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .DEPTH_LOG2(DL),
    .READ_LATENCY(RL), .CALIB_CYCLES(CC), .REFRESH_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .init_calib_complete(init_calib_complete)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  typedef struct { logic [DW-1:0] d; logic [MW-1:0] m; } beat_t;

  int n_chk = 0;
  int n_fail = 0;
  int tmo = 0;

  // Directed expectations raised by the stimulus for the current cycle.
  bit chk_rdy_en = 0, exp_rdy = 0;
  bit chk_wrdy_en = 0, exp_wrdy = 0;
  bit chk_init_en = 0, exp_init = 0;
  bit ref_mon = 0, final_chk = 0;

  // Reference model state (owned by the monitor).
  logic [DW-1:0] mem_m [1 << DL];
  exp_t          exp_q [$];
  beat_t         beats [$];
  bit            wpend = 0;
  int            widx_m = 0;
  logic [DW-1:0] last = '0;
  bit            ref_mon_q = 0, seen_rdy = 0, have_prev = 0;
  int            run = 0, rstart = 0, prev_start = 0, n_runs = 0;

  task automatic check(input bit ok, input string nm,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply(input int idx, input beat_t b);
    for (int i = 0; i < MW; i++)
      if (!b.m[i]) mem_m[idx][i*8 +: 8] = b.d[i*8 +: 8];
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      beats.delete();
      wpend = 0;
      last = '0;
    end else begin
      check(app_rd_data_end === app_rd_data_valid, "rd_end",
            DW'(app_rd_data_end), DW'(app_rd_data_valid));
      if (app_rd_data_valid) begin
        check(exp_q.size() > 0, "rd_unexpected", DW'(1), DW'(0));
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check(app_rd_data === e.data, "rd_data", app_rd_data, e.data);
          check(cyc == e.due, "rd_latency", DW'(cyc), DW'(e.due));
          last = e.data;
        end
      end else begin
        check(app_rd_data === last, "rd_hold", app_rd_data, last);
      end
      if (chk_rdy_en)
        check(app_rdy === exp_rdy, "app_rdy", DW'(app_rdy), DW'(exp_rdy));
      if (chk_wrdy_en)
        check(app_wdf_rdy === exp_wrdy, "app_wdf_rdy",
              DW'(app_wdf_rdy), DW'(exp_wrdy));
      if (chk_init_en)
        check(init_calib_complete === exp_init, "init_calib",
              DW'(init_calib_complete), DW'(exp_init));
      // Model: pair write commands with beats in arrival order.
      if (app_wdf_wren && app_wdf_rdy)
        beats.push_back('{app_wdf_data, app_wdf_mask});
      if (wpend && beats.size() > 0) begin
        apply(widx_m, beats.pop_front());
        wpend = 0;
      end
      if (app_en && app_rdy) begin
        int ix;
        ix = int'(app_addr[DL+2:3]);
        if (app_cmd == 3'b000) begin
          if (beats.size() > 0) apply(ix, beats.pop_front());
          else begin
            wpend = 1;
            widx_m = ix;
          end
        end else if (app_cmd == 3'b001) begin
          exp_q.push_back('{mem_m[ix], cyc + RL});
        end
      end
      if (ref_mon) begin
        if (!ref_mon_q) begin
          seen_rdy = 0; run = 0; have_prev = 0; n_runs = 0;
        end
        if (app_rdy) begin
          if (run > 0 && seen_rdy) begin
            check(run == 4, "refresh_len", DW'(run), DW'(4));
            if (have_prev)
              check(rstart - prev_start == RP, "refresh_period",
                    DW'(rstart - prev_start), DW'(RP));
            prev_start = rstart;
            have_prev = 1;
            n_runs++;
          end
          run = 0;
          seen_rdy = 1;
        end else begin
          if (run == 0) rstart = cyc;
          run++;
        end
      end
      ref_mon_q = ref_mon;
      if (final_chk) begin
        check(exp_q.size() == 0, "reads_outstanding",
              DW'(exp_q.size()), DW'(0));
        check(!wpend, "write_pending", DW'(wpend), DW'(0));
        check(tmo == 0, "handshake_timeout", DW'(tmo), DW'(0));
        check(n_runs >= 2, "refresh_runs", DW'(n_runs), DW'(2));
      end
    end
  end

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [MW-1:0] rndmask();
    return ($urandom % 2) ? '0 : MW'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit c_on, input logic [2:0] cmd,
                      input logic [AW-1:0] addr, input bit d_on,
                      input logic [DW-1:0] data, input logic [MW-1:0] mask);
    bit pc, pd, ac, ad;
    int n;
    pc = c_on; pd = d_on; n = 0;
    app_cmd = cmd; app_addr = addr;
    app_wdf_data = data; app_wdf_mask = mask;
    while ((pc || pd) && n < 200) begin
      app_en = pc;
      app_wdf_wren = pd;
      ac = pc && app_rdy;
      ad = pd && app_wdf_rdy;
      tick();
      if (ac) pc = 0;
      if (ad) pd = 0;
      n++;
    end
    app_en = 0;
    app_wdf_wren = 0;
    if (pc || pd) tmo++;
  endtask

  task automatic rand_drive(input bit hold);
    int r;
    r = $urandom % 10;
    app_en = hold ? 1'b1 : 1'($urandom % 2);
    if (hold) app_cmd = 3'($urandom % 2);
    else app_cmd = (r < 5) ? 3'b001 : (r < 9) ? 3'b000 : 3'(2 + $urandom % 6);
    app_addr = AW'($urandom);
    app_wdf_wren = hold ? 1'b1 : 1'($urandom % 2);
    app_wdf_data = rnd128();
    app_wdf_mask = rndmask();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    // Calibration window: 16 cycles not ready, ready on cycle 17.
    chk_rdy_en = 1; chk_wrdy_en = 1; chk_init_en = 1;
    for (int k = 1; k <= 17; k++) begin
      exp_rdy = (k == 17);
      exp_wrdy = (k == 17);
      exp_init = (k == 17);
      tick();
    end
    chk_rdy_en = 0; chk_wrdy_en = 0; chk_init_en = 0;

    // Fill every word so later reads have defined data.
    for (int i = 0; i < (1 << DL); i++)
      xfer(1, 3'b000, AW'({$urandom % 4096, 8'(i), 3'($urandom)}),
           1, rnd128(), '0);

    xfer(1, 3'b000, AW'('h10), 1,
         128'hcafecafe_faceface_babebabe_beadbead, '0);
    xfer(1, 3'b001, AW'('h10), 0, '0, '0);

    // Write command with its data three cycles later.
    xfer(1, 3'b000, AW'('h18), 0, '0, '0);
    chk_rdy_en = 1; exp_rdy = 0;
    tick();
    tick();
    app_wdf_wren = 1;
    app_wdf_data = rnd128();
    app_wdf_mask = 16'h000F;
    chk_wrdy_en = 1; exp_wrdy = 1;
    tick();
    app_wdf_wren = 0;
    chk_wrdy_en = 0;
    exp_rdy = 1;
    tick();
    chk_rdy_en = 0;
    xfer(1, 3'b001, AW'('h18), 0, '0, '0);

    xfer(1, 3'b001, AW'('h00), 0, '0, '0);
    xfer(1, 3'b001, AW'('h08), 0, '0, '0);
    xfer(1, 3'b001, AW'('h10), 0, '0, '0);
    repeat (RL + 2) tick();

    // Random traffic with a reset in the middle of it.
    for (int i = 0; i < 600; i++) begin
      rand_drive(0);
      if (i == 250) reset = 1;
      if (i == 252) reset = 0;
      tick();
    end
    app_en = 0; app_wdf_wren = 0;
    repeat (10) tick();

    // Saturated command stream to observe refresh stalls.
    ref_mon = 1;
    for (int i = 0; i < 200; i++) begin
      rand_drive(1);
      tick();
    end
    app_en = 0; app_wdf_wren = 0;
    tick();
    ref_mon = 0;
    repeat (RL + 5) tick();
    final_chk = 1;
    tick();
    final_chk = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
